sha_const_store: RTL and testbench

SHA_CONST_STORE -- requirements
Module: sha_const_store

---
 rtl/sha_const_store.sv | 193 +++++++++++++++++++
 tb/tb_sha_const_store.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_const_store.sv
// SHA constant store: copies K and one selected H set from ROM into RAM.
// Ports: CLK/RST, copy control (COPY_*), ROM read (ROM_*), reads (RD_*).
module sha_const_store #(
  parameter int DATA_W  = 32,
  parameter int H_DEPTH = 8,
  parameter int K_DEPTH = 64,
  parameter int NSETS   = 2,
  parameter int ROM_AW  = 13,
  localparam int H_AW   = $clog2(H_DEPTH),
  localparam int K_AW   = $clog2(K_DEPTH),
  localparam int S_AW   = (NSETS > 1) ? $clog2(NSETS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              COPY_START,
  input  logic [S_AW-1:0]   SET_SEL,
  output logic              COPY_BUSY,
  output logic              COPY_DONE,
  output logic              ROM_RE,
  output logic [ROM_AW-1:0] ROM_A,
  input  logic [DATA_W-1:0] ROM_D,
  input  logic              RD_EN,
  input  logic              HK_SELECTOR,
  input  logic [H_AW-1:0]   H_ADDR,
  input  logic [K_AW-1:0]   K_ADDR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic              RD_ERR
);

  localparam int N    = H_DEPTH + K_DEPTH;
  localparam int I_AW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COPY,
    S_FLUSH,
    S_READY
  } state_t;

  state_t              state_q, state_d;
  logic [I_AW-1:0]     idx_q, idx_d;
  logic [S_AW-1:0]     set_q, set_d;
  logic                rom_re_q, rom_re_d;
  logic [ROM_AW-1:0]   rom_a_q, rom_a_d;
  logic                wr_en_q, wr_en_d;
  logic [I_AW-1:0]     wr_slot_q, wr_slot_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_err_q, rd_err_d;

  logic [DATA_W-1:0]   mem_q [N];

  logic                h_ok;
  logic                k_ok;
  logic [DATA_W-1:0]   h_word;
  logic [DATA_W-1:0]   k_word;

  // Copy order is K first, then the selected H set.
  function automatic logic [ROM_AW-1:0] rom_addr(
    input logic [I_AW-1:0] i,
    input logic [S_AW-1:0] s
  );
    if (i < I_AW'(K_DEPTH)) begin
      return ROM_AW'(i);
    end
    return ROM_AW'(i) + ROM_AW'(s) * ROM_AW'(H_DEPTH);
  endfunction

  // H lives in slots 0.., K after it.
  function automatic logic [I_AW-1:0] dest_slot(
    input logic [I_AW-1:0] i
  );
    if (i < I_AW'(K_DEPTH)) begin
      return I_AW'(H_DEPTH) + i;
    end
    return i - I_AW'(K_DEPTH);
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    set_d     = set_q;
    rom_re_d  = 1'b0;
    rom_a_d   = '0;
    wr_en_d   = 1'b0;
    wr_slot_d = wr_slot_q;
    busy_d    = busy_q;
    done_d    = done_q;
    unique case (state_q)
      S_IDLE, S_READY: begin
        if (COPY_START) begin
          state_d  = S_COPY;
          idx_d    = '0;
          set_d    = SET_SEL;
          rom_re_d = 1'b1;
          rom_a_d  = rom_addr('0, SET_SEL);
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      S_COPY: begin
        // ROM data for idx_q arrives next cycle.
        wr_en_d   = 1'b1;
        wr_slot_d = dest_slot(idx_q);
        if (idx_q == I_AW'(N - 1)) begin
          state_d = S_FLUSH;
        end else begin
          idx_d    = idx_q + 1'b1;
          rom_re_d = 1'b1;
          rom_a_d  = rom_addr(idx_q + 1'b1, set_q);
        end
      end
      S_FLUSH: begin
        state_d = S_READY;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign h_ok = ({1'b0, H_ADDR} < (H_AW + 1)'(H_DEPTH));
  assign k_ok = ({1'b0, K_ADDR} < (K_AW + 1)'(K_DEPTH));

  assign h_word = h_ok ? mem_q[I_AW'(H_ADDR)] : '0;
  assign k_word = k_ok ?
    mem_q[I_AW'(H_DEPTH) + I_AW'(K_ADDR)] : '0;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    if (RD_EN) begin
      if (state_q == S_READY) begin
        rd_valid_d = 1'b1;
        rd_data_d  = HK_SELECTOR ? k_word : h_word;
      end else begin
        rd_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      set_q      <= '0;
      rom_re_q   <= 1'b0;
      rom_a_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_slot_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      set_q      <= set_d;
      rom_re_q   <= rom_re_d;
      rom_a_q    <= rom_a_d;
      wr_en_q    <= wr_en_d;
      wr_slot_q  <= wr_slot_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // Contents survive reset; a pending write is dropped with wr_en_q.
  always_ff @(posedge CLK) begin
    if (wr_en_q) begin
      mem_q[wr_slot_q] <= ROM_D;
    end
  end

  assign COPY_BUSY = busy_q;
  assign COPY_DONE = done_q;
  assign ROM_RE    = rom_re_q;
  assign ROM_A     = rom_a_q;
  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;
  assign RD_ERR    = rd_err_q;

endmodule

// File: tb/tb_sha_const_store.sv
// Bench for sha_const_store: ROM model, copy sequencing, scoreboarded reads.
// Reads push expectations; a monitor pops them when RD_VALID/RD_ERR shows.
module tb_sha_const_store;

  localparam int N = 72;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        copy_start;
  logic [0:0]  set_sel;
  logic        copy_busy;
  logic        copy_done;
  logic        rom_re;
  logic [12:0] rom_a;
  logic [31:0] rom_d;
  logic        rd_en;
  logic        hk;
  logic [2:0]  h_addr;
  logic [5:0]  k_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_err;

  int checks   = 0;
  int failures = 0;

  exp_t        sb [$];
  bit          ready_m = 1'b0;
  logic [31:0] last_d = '0;
  logic [31:0] model [N];

  logic [31:0] rom [80] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2,
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  sha_const_store dut (
    .CLK         (clk),
    .RST         (rst),
    .COPY_START  (copy_start),
    .SET_SEL     (set_sel),
    .COPY_BUSY   (copy_busy),
    .COPY_DONE   (copy_done),
    .ROM_RE      (rom_re),
    .ROM_A       (rom_a),
    .ROM_D       (rom_d),
    .RD_EN       (rd_en),
    .HK_SELECTOR (hk),
    .H_ADDR      (h_addr),
    .K_ADDR      (k_addr),
    .RD_DATA     (rd_data),
    .RD_VALID    (rd_valid),
    .RD_ERR      (rd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_re) begin
      rom_d <= (rom_a < 13'd80) ? rom[rom_a[6:0]] : 32'hdeadbeef;
    end
  end

  always @(negedge clk) begin
    if (!rom_re) begin
      checks++;
      if (rom_a != 13'd0) begin
        failures++;
        $display("FAIL rom_a_idle got=%h exp=0", rom_a);
      end
    end
  end

  always begin
    exp_t got;
    exp_t e;
    @(posedge clk);
    #1;
    if (rd_valid || rd_err) begin
      got = {rd_valid, rd_err, rd_data};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got v=%0b e=%0b d=%h",
                 rd_valid, rd_err, rd_data);
      end else begin
        e = sb.pop_front();
        if (got != e) begin
          failures++;
          $display("FAIL rd_resp got v=%0b e=%0b d=%h exp v=%0b e=%0b d=%h",
                   got.v, got.e, got.d, e.v, e.e, e.d);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic int exp_a(input int i, input int s);
    return (i < 64) ? i : i + s * 8;
  endfunction

  task automatic load_model(input int s);
    for (int i = 0; i < 64; i++) model[8 + i] = rom[i];
    for (int h = 0; h < 8; h++) model[h] = rom[64 + s * 8 + h];
  endtask

  task automatic push_rd(input logic sel, input int a);
    exp_t x;
    if (ready_m) begin
      x.v = 1'b1;
      x.e = 1'b0;
      x.d = sel ? model[8 + a] : model[a];
      last_d = x.d;
    end else begin
      x.v = 1'b0;
      x.e = 1'b1;
      x.d = last_d;
    end
    sb.push_back(x);
  endtask

  task automatic rd(input logic sel, input int a);
    @(negedge clk);
    rd_en  = 1'b1;
    hk     = sel;
    h_addr = 3'(a);
    k_addr = 6'(a);
    push_rd(sel, a);
  endtask

  task automatic rd_idle();
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_copy(input int s, input int ign_at,
                         input int err_at, input bit with_read);
    int cyc;
    int bad;
    @(negedge clk);
    copy_start = 1'b1;
    set_sel    = 1'(s);
    if (with_read) begin
      rd_en  = 1'b1;
      hk     = 1'b0;
      h_addr = 3'd0;
      push_rd(1'b0, 0);
    end
    @(posedge clk);
    #1;
    copy_start = 1'b0;
    rd_en      = 1'b0;
    ready_m    = 1'b0;
    cyc = 0;
    bad = 0;
    while (!copy_done && cyc < 200) begin
      if (cyc < N) begin
        if (!rom_re || rom_a != 13'(exp_a(cyc, s))) bad++;
      end else if (rom_re) begin
        bad++;
      end
      if (!copy_busy) bad++;
      copy_start = (cyc == ign_at);
      if (cyc == err_at) begin
        rd_en  = 1'b1;
        hk     = 1'b1;
        k_addr = 6'd5;
        push_rd(1'b1, 5);
      end else begin
        rd_en = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    copy_start = 1'b0;
    rd_en      = 1'b0;
    chk("copy_seq", bad, 0);
    chk("copy_latency", cyc, 73);
    chk("busy_after_done", {31'd0, copy_busy}, 0);
    load_model(s);
    ready_m = 1'b1;
  endtask

  initial begin
    rst        = 1'b1;
    copy_start = 1'b0;
    set_sel    = 1'b0;
    rd_en      = 1'b0;
    hk         = 1'b0;
    h_addr     = '0;
    k_addr     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, copy_busy}, 0);
    chk("rst_done", {31'd0, copy_done}, 0);
    chk("rst_rom_re", {31'd0, rom_re}, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 0);
    rst = 1'b0;

    rd(1'b0, 0);
    rd_idle();

    do_copy(0, -1, -1, 1'b0);
    for (int i = 0; i < 64; i++) rd(1'b1, i);
    for (int i = 0; i < 8; i++) rd(1'b0, i);
    rd_idle();

    do_copy(1, 10, 20, 1'b0);
    for (int i = 0; i < 8; i++) rd(1'b0, i);
    for (int i = 0; i < 3; i++) rd(1'b1, i);
    rd_idle();

    do_copy(0, -1, -1, 1'b1);
    for (int i = 0; i < 3; i++) rd(1'b0, i);
    rd_idle();

    @(negedge clk);
    copy_start = 1'b1;
    set_sel    = 1'b0;
    @(posedge clk);
    #1;
    copy_start = 1'b0;
    ready_m    = 1'b0;
    for (int c = 0; c < 30; c++) @(posedge clk);
    #1;
    chk("abort_rom_a", {19'd0, rom_a}, 30);
    rst        = 1'b1;
    copy_start = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    copy_start = 1'b0;
    last_d     = '0;
    chk("abort_busy", {31'd0, copy_busy}, 0);
    chk("abort_rom_re", {31'd0, rom_re}, 0);
    chk("abort_rd_data", rd_data, 0);
    rd(1'b1, 3);
    rd_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("abort_done", {31'd0, copy_done}, 0);

    do_copy(0, -1, -1, 1'b0);
    for (int i = 61; i < 64; i++) rd(1'b1, i);
    rd_idle();

    repeat (5) @(posedge clk);
    #2;
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
